// File: rtl/udp_rx_payload.sv
// GMII receive parser: preamble/SFD, Ethernet, IPv4 and UDP headers, payload pushed to a write FIFO.
// Optional IPv4 header checksum verification is built when IP_HDR_CHECK_EN is defined.
//
// state      | meaning
// S_IDLE     | waiting for the first preamble byte
// S_PREAMBLE | counting 0x55 bytes, expecting SFD 0xD5
// S_ETH_HDR  | destination MAC and EtherType check
// S_IP_HDR   | version/IHL, protocol, destination IP (and checksum) check
// S_UDP_HDR  | destination port and length capture
// S_PAYLOAD  | payload bytes forwarded to the FIFO
// S_WAIT_END | padding/FCS skipped until e_rxdv falls
// S_DROP     | frame rejected, skip until e_rxdv falls
module udp_rx_payload #(
  parameter logic [47:0] BOARD_MAC = 48'h000A3501FEC0,
  parameter logic [31:0] BOARD_IP  = 32'hC0A80002,
  parameter logic [15:0] UDP_PORT  = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        reset,
  input  logic [7:0]  e_rxd,
  input  logic        e_rxdv,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] rx_data_length
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_WAIT_END, S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_cnt;
  logic [15:0] r_pay_len;
  logic [7:0]  r_hi_byte;
  logic        r_mac_board;
  logic        r_mac_bcast;
  logic        r_ovf;
  logic        r_end_pend;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [15:0] r_rx_len;

  logic [47:0] w_mac_sh;
  logic [31:0] w_ip_sh;
  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic        w_first;
  logic        w_mac_board;
  logic        w_mac_bcast;
  logic [15:0] w_udp_len;
  logic        w_eth_bad;
  logic        w_ip_bad;
  logic        w_csum_bad;
  logic        w_udp_bad;
  logic        w_last;

  logic        w_wr_req;
  logic        w_ovf_set;
  logic        w_end_req;
  logic        w_trunc;

  // Expected header bytes are picked out of the parameters by byte index.
  assign w_mac_sh    = BOARD_MAC << {r_cnt[2:0], 3'b000};
  assign w_ip_sh     = BOARD_IP << {r_cnt[1:0], 3'b000};
  assign w_mac_byte  = w_mac_sh[47:40];
  assign w_ip_byte   = w_ip_sh[31:24];
  assign w_first     = (r_cnt == 16'd0);
  assign w_mac_board = (w_first | r_mac_board) & (e_rxd == w_mac_byte);
  assign w_mac_bcast = (w_first | r_mac_bcast) & (e_rxd == 8'hFF);
  assign w_udp_len   = {r_hi_byte, e_rxd};
  assign w_last      = (r_cnt == (r_pay_len - 16'd1));

  assign w_eth_bad = ((r_cnt == 16'd5) & ~(w_mac_board | w_mac_bcast)) |
                     ((r_cnt == 16'd12) & (e_rxd != 8'h08)) |
                     ((r_cnt == 16'd13) & (e_rxd != 8'h00));

  assign w_ip_bad  = ((r_cnt == 16'd0) & (e_rxd != 8'h45)) |
                     ((r_cnt == 16'd9) & (e_rxd != 8'h11)) |
                     ((r_cnt >= 16'd16) & (r_cnt <= 16'd19) & (e_rxd != w_ip_byte));

`ifdef IP_HDR_CHECK_EN
  logic [15:0] r_csum;
  logic [16:0] w_csum_sum;

  assign w_csum_sum = {1'b0, r_csum} + {1'b0, r_hi_byte, e_rxd};
  assign w_csum_bad = (r_cnt == 16'd0) & (r_csum != 16'hFFFF);

  // End-around carry folds back in the same cycle; the fold itself cannot carry again.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      r_csum <= 16'd0;
    end else if ((r_state == S_IP_HDR) && e_rxdv) begin
      if (r_cnt == 16'd0)
        r_csum <= 16'd0;
      else if (r_cnt[0])
        r_csum <= w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
    end
  end
`else
  assign w_csum_bad = 1'b0;
`endif

  assign w_udp_bad = w_csum_bad |
                     ((r_cnt == 16'd2) & (e_rxd != UDP_PORT[15:8])) |
                     ((r_cnt == 16'd3) & (e_rxd != UDP_PORT[7:0])) |
                     ((r_cnt == 16'd5) & (w_udp_len < 16'd8));

  always_ff @(posedge e_rxc) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (e_rxdv && (e_rxd == 8'h55)) w_next = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (!e_rxdv)
          w_next = S_IDLE;
        else if (r_cnt < 16'd6) begin
          if (e_rxd != 8'h55) w_next = S_DROP;
        end else if (e_rxd == 8'hD5)
          w_next = S_ETH_HDR;
        else
          w_next = S_DROP;
      end
      S_ETH_HDR: begin
        if (!e_rxdv)                w_next = S_IDLE;
        else if (w_eth_bad)         w_next = S_DROP;
        else if (r_cnt == 16'd13)   w_next = S_IP_HDR;
      end
      S_IP_HDR: begin
        if (!e_rxdv)                w_next = S_IDLE;
        else if (w_ip_bad)          w_next = S_DROP;
        else if (r_cnt == 16'd19)   w_next = S_UDP_HDR;
      end
      S_UDP_HDR: begin
        if (!e_rxdv)                w_next = S_IDLE;
        else if (w_udp_bad)         w_next = S_DROP;
        else if (r_cnt == 16'd7)    w_next = (r_pay_len == 16'd0) ? S_WAIT_END : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!e_rxdv)                w_next = S_IDLE;
        else if (w_last)            w_next = S_WAIT_END;
      end
      S_WAIT_END, S_DROP: begin
        if (!e_rxdv)                w_next = S_IDLE;
      end
      default:                      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_req  = 1'b0;
    w_ovf_set = 1'b0;
    w_end_req = 1'b0;
    w_trunc   = 1'b0;
    case (r_state)
      S_UDP_HDR: begin
        if (e_rxdv && (r_cnt == 16'd7) && (r_pay_len == 16'd0)) w_end_req = 1'b1;
      end
      S_PAYLOAD: begin
        if (e_rxdv) begin
          w_wr_req  = ~fifo_full;
          w_ovf_set = fifo_full;
          w_end_req = w_last;
        end else begin
          w_trunc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Completion is held one extra cycle so the pulse lands after the final FIFO write.
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      r_cnt        <= 16'd0;
      r_pay_len    <= 16'd0;
      r_hi_byte    <= 8'd0;
      r_mac_board  <= 1'b0;
      r_mac_bcast  <= 1'b0;
      r_ovf        <= 1'b0;
      r_end_pend   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= 8'd0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_len     <= 16'd0;
    end else begin
      if (w_next != r_state)
        r_cnt <= 16'd0;
      else if (e_rxdv)
        r_cnt <= r_cnt + 16'd1;

      if ((r_state == S_ETH_HDR) && e_rxdv && (r_cnt < 16'd6)) begin
        r_mac_board <= w_mac_board;
        r_mac_bcast <= w_mac_bcast;
      end

      if (((r_state == S_IP_HDR) || (r_state == S_UDP_HDR)) && e_rxdv && !r_cnt[0])
        r_hi_byte <= e_rxd;

      if ((r_state == S_UDP_HDR) && e_rxdv && (r_cnt == 16'd5))
        r_pay_len <= w_udp_len - 16'd8;

      if (r_state == S_IDLE)
        r_ovf <= 1'b0;
      else if (w_ovf_set)
        r_ovf <= 1'b1;

      r_wr_en <= w_wr_req;
      if (w_wr_req)
        r_wr_data <= e_rxd;

      r_end_pend   <= w_end_req;
      r_frame_done <= r_end_pend & ~r_ovf;
      r_frame_err  <= (r_end_pend & r_ovf) | w_trunc;
      if (r_end_pend || w_trunc)
        r_rx_len <= r_pay_len;
    end
  end

  assign fifo_wr_en     = r_wr_en;
  assign fifo_wr_data   = r_wr_data;
  assign frame_done     = r_frame_done;
  assign frame_err      = r_frame_err;
  assign rx_data_length = r_rx_len;

endmodule

// File: tb/tb_udp_rx_payload.sv
// Bench for udp_rx_payload: directed frame table, hand sequences for reset/back-to-back,
// and random frames checked against an offset-based frame parsing model.
module tb_udp_rx_payload;
  localparam logic [47:0] BOARD_MAC = 48'h000A3501FEC0;
  localparam logic [31:0] BOARD_IP  = 32'hC0A80002;
  localparam logic [15:0] UDP_PORT  = 16'd8080;

  logic        e_rxc = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  e_rxd = 8'd0;
  logic        e_rxdv = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] rx_data_length;

  udp_rx_payload dut (
    .e_rxc(e_rxc), .reset(reset), .e_rxd(e_rxd), .e_rxdv(e_rxdv), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .frame_done(frame_done),
    .frame_err(frame_err), .rx_data_length(rx_data_length)
  );

  always #5 e_rxc = ~e_rxc;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  got_q[$];
  int          done_n = 0;
  int          err_n = 0;
  logic [15:0] last_len = 16'd0;

  always @(negedge e_rxc) begin
    if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    if (frame_done) begin done_n++; last_len = rx_data_length; end
    if (frame_err)  begin err_n++;  last_len = rx_data_length; end
  end

  logic [7:0] fr_q[$];
  bit         fr_full[$];
  logic [7:0] m_q[$];
  int         m_done, m_err, m_len;
  int         bw, bd, be;

  typedef struct {
    bit          bcast;
    int          fault;
    logic [15:0] port;
    logic [15:0] ulen;
    int          send_n;
    int          fs;
    int          fn;
    bit          trailer;
    int          exp_wr;
    int          exp_done;
    int          exp_err;
    int          exp_len;
  } vec_t;

  vec_t tv[18];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    fr_q.push_back(b);
    fr_full.push_back(($urandom % 2) == 1);
  endtask

  // fault: 1 MAC, 2 EtherType, 3 IP version/IHL, 4 protocol, 5 dest IP, 6 IP checksum, 7 short preamble
  task automatic build_frame(input bit bcast, input int fault, input logic [15:0] port,
                             input logic [15:0] ulen, input int send_n, input int fs,
                             input int fn, input int full_pct, input bit trailer);
    logic [47:0] mac;
    logic [7:0]  ip[20];
    logic [15:0] tot, etype, c;
    logic [31:0] s, dip;
    fr_q.delete();
    fr_full.delete();
    for (int i = 0; i < ((fault == 7) ? 6 : 7); i++) push_b(8'h55);
    push_b(8'hD5);
    mac = (fault == 1) ? (BOARD_MAC ^ 48'h1) : (bcast ? 48'hFFFF_FFFF_FFFF : BOARD_MAC);
    for (int k = 0; k < 6; k++) push_b(mac[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) push_b(8'($urandom));
    etype = (fault == 2) ? 16'h86DD : 16'h0800;
    push_b(etype[15:8]);
    push_b(etype[7:0]);
    tot = 16'd20 + ulen;
    dip = (fault == 5) ? 32'hC0A80009 : BOARD_IP;
    ip[0] = (fault == 3) ? 8'h46 : 8'h45;  ip[1] = 8'h00;
    ip[2] = tot[15:8];  ip[3] = tot[7:0];
    ip[4] = 8'($urandom); ip[5] = 8'($urandom);
    ip[6] = 8'h40; ip[7] = 8'h00; ip[8] = 8'h40;
    ip[9] = (fault == 4) ? 8'h06 : 8'h11;
    ip[10] = 8'h00; ip[11] = 8'h00;
    ip[12] = 8'hC0; ip[13] = 8'hA8; ip[14] = 8'h00; ip[15] = 8'h03;
    ip[16] = dip[31:24]; ip[17] = dip[23:16]; ip[18] = dip[15:8]; ip[19] = dip[7:0];
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, ip[2*w], ip[2*w+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    c = ~s[15:0];
    ip[10] = c[15:8];
    ip[11] = c[7:0];
    if (fault == 6) ip[10] = ip[10] ^ 8'h01;
    for (int k = 0; k < 20; k++) push_b(ip[k]);
    push_b(8'($urandom)); push_b(8'($urandom));
    push_b(port[15:8]);   push_b(port[7:0]);
    push_b(ulen[15:8]);   push_b(ulen[7:0]);
    push_b(8'($urandom)); push_b(8'($urandom));
    for (int i = 0; i < send_n; i++) begin
      fr_q.push_back(8'($urandom));
      fr_full.push_back(((i >= fs) && (i < fs + fn)) || (int'($urandom_range(0, 99)) < full_pct));
    end
    if (trailer) for (int k = 0; k < 4; k++) push_b(8'($urandom));
  endtask

  // Parses the byte list by fixed header offsets: preamble 0-7, Ethernet 8-21,
  // IPv4 22-41, UDP 42-49, payload from 50.
  task automatic model_frame();
    bit          ok;
    logic [47:0] mac;
    logic [31:0] ipa;
    logic [15:0] ulen;
    bit          bm, bc, ovf;
    int          pay, avail, n;
`ifdef IP_HDR_CHECK_EN
    logic [31:0] s;
`endif
    m_q.delete();
    m_done = 0; m_err = 0; m_len = 0;
    mac = BOARD_MAC;
    ipa = BOARD_IP;
    ok = (fr_q.size() >= 50);
    if (ok) begin
      for (int i = 0; i < 7; i++) if (fr_q[i] != 8'h55) ok = 0;
      if (fr_q[7] != 8'hD5) ok = 0;
      bm = 1; bc = 1;
      for (int k = 0; k < 6; k++) begin
        if (fr_q[8+k] != mac[47-8*k -: 8]) bm = 0;
        if (fr_q[8+k] != 8'hFF) bc = 0;
      end
      if (!(bm || bc)) ok = 0;
      if (fr_q[20] != 8'h08 || fr_q[21] != 8'h00) ok = 0;
      if (fr_q[22] != 8'h45 || fr_q[31] != 8'h11) ok = 0;
      for (int k = 0; k < 4; k++) if (fr_q[38+k] != ipa[31-8*k -: 8]) ok = 0;
`ifdef IP_HDR_CHECK_EN
      s = 32'd0;
      for (int w = 0; w < 10; w++) s = s + {16'd0, fr_q[22+2*w], fr_q[23+2*w]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      if (s[15:0] != 16'hFFFF) ok = 0;
`endif
      if ({fr_q[44], fr_q[45]} != UDP_PORT) ok = 0;
      ulen = {fr_q[46], fr_q[47]};
      if (ulen < 16'd8) ok = 0;
      if (ok) begin
        pay = int'(ulen) - 8;
        avail = fr_q.size() - 50;
        n = (pay < avail) ? pay : avail;
        ovf = 0;
        for (int i = 0; i < n; i++) begin
          if (fr_full[50+i]) ovf = 1;
          else m_q.push_back(fr_q[50+i]);
        end
        if (avail < pay || ovf) m_err = 1;
        else m_done = 1;
        m_len = pay;
      end
    end
  endtask

  task automatic drive_bytes(input int upto);
    for (int i = 0; i < upto; i++) begin
      @(posedge e_rxc); #1;
      e_rxdv = 1'b1;
      e_rxd = fr_q[i];
      fifo_full = fr_full[i];
    end
  endtask

  task automatic idle(input int cycles);
    @(posedge e_rxc); #1;
    e_rxdv = 1'b0;
    e_rxd = 8'd0;
    fifo_full = 1'b0;
    repeat (cycles - 1) @(posedge e_rxc);
    #1;
  endtask

  task automatic mark();
    bw = got_q.size();
    bd = done_n;
    be = err_n;
  endtask

  task automatic check_data(input string tag);
    int mm;
    int act;
    mm = -1;
    act = got_q.size() - bw;
    for (int i = 0; i < act && i < m_q.size(); i++)
      if (mm < 0 && got_q[bw+i] != m_q[i]) mm = i;
    check({tag, "_data_first_bad_idx"}, mm, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string tag;
    bit b;
    int flt, ul, pay, sn;
    logic [15:0] prt;

    tv[0]  = '{0, 0, 16'd8080, 16'd18,   10,   0, 0, 1, 10,   1, 0, 10};
    tv[1]  = '{0, 0, 16'd8081, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[2]  = '{0, 0, 16'd8080, 16'd18,   10,   0, 0, 1, 10,   1, 0, 10};
    tv[3]  = '{1, 0, 16'd8080, 16'd1480, 1472, 0, 0, 1, 1472, 1, 0, 1472};
    tv[4]  = '{0, 0, 16'd8080, 16'd18,   10,   2, 3, 1, 7,    0, 1, 10};
    tv[5]  = '{0, 0, 16'd8080, 16'd18,   5,    0, 0, 0, 5,    0, 1, 10};
    tv[6]  = '{0, 0, 16'd8080, 16'd8,    0,    0, 0, 1, 0,    1, 0, 0};
    tv[7]  = '{0, 0, 16'd8080, 16'd7,    0,    0, 0, 1, 0,    0, 0, -1};
`ifdef IP_HDR_CHECK_EN
    tv[8]  = '{0, 6, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
`else
    tv[8]  = '{0, 6, 16'd8080, 16'd18,   10,   0, 0, 1, 10,   1, 0, 10};
`endif
    tv[9]  = '{0, 0, 16'd8080, 16'd22,   14,   0, 0, 1, 14,   1, 0, 14};
    tv[10] = '{0, 1, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[11] = '{0, 5, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[12] = '{0, 2, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[13] = '{0, 3, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[14] = '{0, 4, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[15] = '{0, 7, 16'd8080, 16'd18,   10,   0, 0, 1, 0,    0, 0, -1};
    tv[16] = '{0, 0, 16'd8080, 16'd18,   10,   9, 1, 1, 9,    0, 1, 10};
    tv[17] = '{1, 0, 16'd8080, 16'd9,    1,    0, 0, 1, 1,    1, 0, 1};

    repeat (3) @(posedge e_rxc);
    @(negedge e_rxc);
    check("reset_wr_en", int'(fifo_wr_en), 0);
    check("reset_wr_data", int'(fifo_wr_data), 0);
    check("reset_done", int'(frame_done), 0);
    check("reset_err", int'(frame_err), 0);
    check("reset_len", int'(rx_data_length), 0);
    @(posedge e_rxc); #1;
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 18; i++) begin
      tag = $sformatf("vec%0d", i);
      build_frame(tv[i].bcast, tv[i].fault, tv[i].port, tv[i].ulen, tv[i].send_n,
                  tv[i].fs, tv[i].fn, 0, tv[i].trailer);
      model_frame();
      mark();
      drive_bytes(fr_q.size());
      idle(6);
      check({tag, "_writes"}, got_q.size() - bw, tv[i].exp_wr);
      check_data(tag);
      check({tag, "_done"}, done_n - bd, tv[i].exp_done);
      check({tag, "_err"}, err_n - be, tv[i].exp_err);
      if (tv[i].exp_len >= 0) check({tag, "_len"}, int'(last_len), tv[i].exp_len);
    end

    // Back-to-back frames with a single idle cycle between them.
    mark();
    build_frame(0, 0, UDP_PORT, 16'd18, 10, 0, 0, 0, 1);
    drive_bytes(fr_q.size());
    idle(1);
    build_frame(1, 0, UDP_PORT, 16'd20, 12, 0, 0, 0, 1);
    drive_bytes(fr_q.size());
    idle(6);
    check("b2b_writes", got_q.size() - bw, 22);
    check("b2b_done", done_n - bd, 2);
    check("b2b_err", err_n - be, 0);
    check("b2b_len", int'(last_len), 12);

    // Reset in the middle of the payload, line still active afterwards.
    mark();
    build_frame(0, 0, UDP_PORT, 16'd18, 10, 0, 0, 0, 1);
    drive_bytes(55);
    @(posedge e_rxc); #1;
    reset = 1'b1;
    e_rxd = 8'h00;
    fifo_full = 1'b0;
    @(posedge e_rxc); #1;
    reset = 1'b0;
    repeat (3) @(posedge e_rxc);
    idle(6);
    check("rstmid_writes", got_q.size() - bw, 5);
    check("rstmid_done", done_n - bd, 0);
    check("rstmid_err", err_n - be, 0);

    // Reset while the completion pulse is pending.
    mark();
    build_frame(0, 0, UDP_PORT, 16'd18, 10, 0, 0, 0, 0);
    drive_bytes(fr_q.size());
    @(posedge e_rxc); #1;
    e_rxdv = 1'b0;
    e_rxd = 8'h00;
    fifo_full = 1'b0;
    reset = 1'b1;
    @(posedge e_rxc); #1;
    reset = 1'b0;
    idle(6);
    check("rstpend_writes", got_q.size() - bw, 10);
    check("rstpend_done", done_n - bd, 0);
    check("rstpend_err", err_n - be, 0);

    mark();
    build_frame(0, 0, UDP_PORT, 16'd18, 10, 0, 0, 0, 1);
    model_frame();
    drive_bytes(fr_q.size());
    idle(6);
    check("after_rst_writes", got_q.size() - bw, 10);
    check_data("after_rst");
    check("after_rst_done", done_n - bd, 1);
    check("after_rst_len", int'(last_len), 10);

    for (int r = 0; r < 40; r++) begin
      tag = $sformatf("rnd%0d", r);
      b = ($urandom % 4) == 0;
      flt = (($urandom % 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      prt = (($urandom % 8) == 0) ? 16'd8081 : UDP_PORT;
      ul = (($urandom % 10) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 72));
      pay = (ul >= 8) ? ul - 8 : 0;
      sn = (pay > 0 && ($urandom % 5) == 0) ? int'($urandom_range(0, pay - 1)) : pay;
      build_frame(b, flt, prt, 16'(ul), sn, 0, 0, 10, sn == pay);
      model_frame();
      mark();
      drive_bytes(fr_q.size());
      idle(int'($urandom_range(1, 3)) + 5);
      check({tag, "_writes"}, got_q.size() - bw, m_q.size());
      check_data(tag);
      check({tag, "_done"}, done_n - bd, m_done);
      check({tag, "_err"}, err_n - be, m_err);
      if (m_done + m_err > 0) check({tag, "_len"}, int'(last_len), m_len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
